// File: rtl/alu_result_latch_if.sv
// Operand/button bundle into the result latch and the held result back out
// to the display decoder. The master drives the switches and raw buttons.
interface alu_result_latch_if;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [1:0] op;
    logic       exec_btn;
    logic       clear_btn;
    logic [3:0] result;
    logic       overflow;
    logic       done;

    modport master (
        output a_in, b_in, op, exec_btn, clear_btn,
        input  result, overflow, done
    );

    modport slave (
        input  a_in, b_in, op, exec_btn, clear_btn,
        output result, overflow, done
    );
endinterface

// File: rtl/alu_result_latch.sv
// Debounces EXEC/CLEAR, runs one 4-bit ALU operation per EXEC press and
// holds the result and signed-overflow flag for the hex display decoder.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for an EXEC press; CLEAR press zeroes the result
//   CAPTURE | one cycle: operands latched on entry, result registered on exit
//   HOLD    | result shown; waiting for EXEC to be released; CLEAR honoured
module alu_result_latch #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_latch_if.slave  bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int BTN_EXEC  = 0;
    localparam int BTN_CLEAR = 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Button input path; bit BTN_EXEC and bit BTN_CLEAR of each vector
    logic [1:0]            btn_raw;
    logic [1:0]            sync_1;
    logic [1:0]            sync_2;
    logic [1:0][CNT_W-1:0] db_cnt;
    logic [1:0]            clean;
    logic [1:0]            clean_d;
    logic [1:0]            press;

    logic exec_press;
    logic clear_press;
    logic exec_level;

    // FSM and datapath
    state_t     state;
    state_t     state_nxt;
    logic       load_ops;
    logic       load_res;
    logic       clr_res;

    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] op_q;
    logic [3:0] alu_res;
    logic       alu_ovf;
    logic [3:0] sum;
    logic [3:0] diff;

    logic [3:0] result_q;
    logic       overflow_q;
    logic       done_q;

    assign btn_raw = {bus.clear_btn, bus.exec_btn};

    // Two-flop synchroniser for the asynchronous raw buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: the synchronised level must differ from the clean level for
    // DEBOUNCE_CYCLES consecutive cycles before the clean level follows it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            clean  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    clean[i]  <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Registered rising-edge detect on the clean levels gives the press pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_d <= '0;
            press   <= '0;
        end else begin
            clean_d <= clean;
            press   <= clean & ~clean_d;
        end
    end

    assign exec_press  = press[BTN_EXEC];
    assign clear_press = press[BTN_CLEAR];
    assign exec_level  = clean[BTN_EXEC];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath controls; CLEAR wins over a simultaneous EXEC
    always_comb begin
        state_nxt = state;
        load_ops  = 1'b0;
        load_res  = 1'b0;
        clr_res   = 1'b0;
        case (state)
            IDLE: begin
                if (clear_press) begin
                    clr_res = 1'b1;
                end else if (exec_press) begin
                    load_ops  = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                load_res  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (clear_press) begin
                    clr_res = 1'b1;
                end else if (!exec_level) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    // ALU on the operands latched when CAPTURE was entered
    always_comb begin
        alu_res = 4'h0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[3] != b_q[3]) && (diff[3] != a_q[3]);
            end
            OP_AND: begin
                alu_res = a_q & b_q;
            end
            OP_OR: begin
                alu_res = a_q | b_q;
            end
            default: begin
                alu_res = 4'h0;
            end
        endcase
    end

    // Operand latch, held result/overflow and the one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= load_res | clr_res;
            if (load_ops) begin
                a_q  <= bus.a_in;
                b_q  <= bus.b_in;
                op_q <= bus.op;
            end
            if (load_res) begin
                result_q   <= alu_res;
                overflow_q <= alu_ovf;
            end else if (clr_res) begin
                result_q   <= '0;
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_result_latch.sv
// Directed bench for alu_result_latch with a short debounce window.
module tb_alu_result_latch;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   done_cnt;

    alu_result_latch_if bus ();

    alu_result_latch #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting done pulses along the way
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done === 1'b1) done_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full EXEC press/release with the given operands
    task automatic exec_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [3:0] exp_r, input logic exp_o);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.op       = op;
        done_cnt     = 0;
        bus.exec_btn = 1'b1;
        run(14);
        chk({tag, " result"}, {4'h0, bus.result}, {4'h0, exp_r});
        chk({tag, " overflow"}, {7'h0, bus.overflow}, {7'h0, exp_o});
        bus.exec_btn = 1'b0;
        run(14);
        chk({tag, " done pulses"}, done_cnt[7:0], 8'd1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        done_cnt      = 0;
        rst           = 1'b1;
        bus.a_in      = 4'h0;
        bus.b_in      = 4'h0;
        bus.op        = 2'b00;
        bus.exec_btn  = 1'b0;
        bus.clear_btn = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("reset result", {4'h0, bus.result}, 8'h00);
        chk("reset overflow", {7'h0, bus.overflow}, 8'h00);
        chk("reset done", {7'h0, bus.done}, 8'h00);

        // ADD 3+4 with exact latency: clean level rises on edge 6, done on edge 9
        bus.a_in     = 4'd3;
        bus.b_in     = 4'd4;
        bus.op       = 2'b00;
        bus.exec_btn = 1'b1;
        repeat (8) tick();
        chk("add latency done early", {7'h0, bus.done}, 8'h00);
        tick();
        chk("add latency done", {7'h0, bus.done}, 8'h01);
        chk("add result", {4'h0, bus.result}, 8'h07);
        chk("add overflow", {7'h0, bus.overflow}, 8'h00);
        tick();
        chk("add done one cycle", {7'h0, bus.done}, 8'h00);
        bus.exec_btn = 1'b0;
        run(14);

        exec_op("add ovf", 4'd7, 4'd1, 2'b00, 4'h8, 1'b1);

        // CLEAR alone drops result and overflow
        done_cnt      = 0;
        bus.clear_btn = 1'b1;
        run(14);
        chk("clear result", {4'h0, bus.result}, 8'h00);
        chk("clear overflow", {7'h0, bus.overflow}, 8'h00);
        bus.clear_btn = 1'b0;
        run(14);
        chk("clear done pulses", done_cnt[7:0], 8'd1);

        exec_op("sub ovf", 4'd8, 4'd1, 2'b01, 4'h7, 1'b1);
        exec_op("sub", 4'd2, 4'd5, 2'b01, 4'hD, 1'b0);

        // Bounce for 20 cycles, then hold high well over 100 cycles
        bus.a_in = 4'd1;
        bus.b_in = 4'd2;
        bus.op   = 2'b00;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bus.exec_btn = ~bus.exec_btn;
            run(2);
        end
        chk("bounce no press", done_cnt[7:0], 8'd0);
        bus.exec_btn = 1'b1;
        run(110);
        chk("held exec pulses", done_cnt[7:0], 8'd1);
        chk("held exec result", {4'h0, bus.result}, 8'h03);
        bus.exec_btn = 1'b0;
        run(14);
        chk("held exec after release", done_cnt[7:0], 8'd1);

        // Clear priority: both buttons rise together with result=5
        exec_op("pre clear", 4'd2, 4'd3, 2'b00, 4'h5, 1'b0);
        bus.a_in      = 4'd1;
        bus.b_in      = 4'd1;
        done_cnt      = 0;
        bus.exec_btn  = 1'b1;
        bus.clear_btn = 1'b1;
        run(14);
        chk("prio result", {4'h0, bus.result}, 8'h00);
        chk("prio overflow", {7'h0, bus.overflow}, 8'h00);
        bus.exec_btn  = 1'b0;
        bus.clear_btn = 1'b0;
        run(14);
        chk("prio done pulses", done_cnt[7:0], 8'd1);
        chk("prio no capture", {4'h0, bus.result}, 8'h00);

        exec_op("and", 4'b1100, 4'b1010, 2'b10, 4'h8, 1'b0);
        exec_op("or", 4'b1100, 4'b1010, 2'b11, 4'hE, 1'b0);

        // Reset mid-debounce with the button still held afterwards
        bus.a_in     = 4'd1;
        bus.b_in     = 4'd1;
        bus.op       = 2'b00;
        bus.exec_btn = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("async rst result", {4'h0, bus.result}, 8'h00);
        chk("async rst overflow", {7'h0, bus.overflow}, 8'h00);
        chk("async rst done", {7'h0, bus.done}, 8'h00);
        repeat (2) tick();
        rst      = 1'b0;
        done_cnt = 0;
        run(14);
        chk("post rst result", {4'h0, bus.result}, 8'h02);
        bus.exec_btn = 1'b0;
        run(14);
        chk("post rst pulses", done_cnt[7:0], 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
